// File: rtl/conv_window_addr_gen_pkg.sv
// rtl/conv_window_addr_gen_pkg.sv - shared FSM encodings, geometry defaults and width helper
package conv_window_addr_gen_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int DEF_IMG_W = 28;
    localparam int DEF_IMG_H = 28;
    localparam int DEF_K     = 5;

    // Bits needed to hold values 0..value-1, never less than one.
    function automatic int clogb2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/conv_window_addr_gen_if.sv
// rtl/conv_window_addr_gen_if.sv - control and address-beat bundle of the window generator
interface conv_window_addr_gen_if #(
    parameter int IA_W = 10,
    parameter int WA_W = 5
);
    logic            start;
    logic            abort;
    logic            out_valid;
    logic            out_ready;
    logic [IA_W-1:0] img_addr;
    logic [WA_W-1:0] w_addr;
    logic            win_first;
    logic            win_last;
    logic            busy;
    logic            done;

    modport master (
        input  start, abort, out_ready,
        output out_valid, img_addr, w_addr, win_first, win_last, busy, done
    );

    modport slave (
        output start, abort, out_ready,
        input  out_valid, img_addr, w_addr, win_first, win_last, busy, done
    );
endinterface

// File: rtl/conv_window_addr_gen_loop_counter.sv
// rtl/conv_window_addr_gen_loop_counter.sv - wrapping 0..STOP-1 counter with carry for cascading
module conv_window_addr_gen_loop_counter
    import conv_window_addr_gen_pkg::*;
#(
    parameter int STOP = 5,
    parameter int W    = clogb2(STOP)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         co
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // co is qualified by en so the next stage in the cascade steps only on a real wrap.
    always_comb begin
        co    = en && (cnt_q == W'(STOP - 1));
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (co)
            cnt_d = '0;
        else if (en)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/conv_window_addr_gen.sv
// rtl/conv_window_addr_gen.sv - sliding-window feature-map and kernel-weight address generator
module conv_window_addr_gen
    import conv_window_addr_gen_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int K     = DEF_K
) (
    input  logic                   clk,
    input  logic                   rst,
    conv_window_addr_gen_if.master bus
);
    localparam int OUT_W = IMG_W - K + 1;
    localparam int OUT_H = IMG_H - K + 1;
    localparam int IA_W  = clogb2(IMG_W * IMG_H);
    localparam int WA_W  = clogb2(K * K);
    localparam int KC_W  = clogb2(K);
    localparam int OC_W  = clogb2(OUT_W);
    localparam int OR_W  = clogb2(OUT_H);

    logic [1:0]      state_q;
    logic [1:0]      state_d;
    logic            run;
    logic            hs;
    logic            clr;
    logic [KC_W-1:0] kcol;
    logic [KC_W-1:0] krow;
    logic [OC_W-1:0] ocol;
    logic [OR_W-1:0] orow;
    logic            kcol_co;
    logic            krow_co;
    logic            ocol_co;
    logic            orow_co;
    logic [IA_W-1:0] row_sum;
    logic [IA_W-1:0] col_sum;

    assign run = (state_q == ST_RUN);
    // abort outranks the handshake, so a beat offered in the abort cycle is not consumed.
    assign hs  = run & bus.out_ready & ~bus.abort;
    assign clr = bus.abort | (bus.start & (state_q == ST_IDLE));

    conv_window_addr_gen_loop_counter #(.STOP(K)) u_kcol (
        .clk(clk), .rst(rst), .clr(clr), .en(hs), .cnt(kcol), .co(kcol_co)
    );
    conv_window_addr_gen_loop_counter #(.STOP(K)) u_krow (
        .clk(clk), .rst(rst), .clr(clr), .en(kcol_co), .cnt(krow), .co(krow_co)
    );
    conv_window_addr_gen_loop_counter #(.STOP(OUT_W)) u_ocol (
        .clk(clk), .rst(rst), .clr(clr), .en(krow_co), .cnt(ocol), .co(ocol_co)
    );
    conv_window_addr_gen_loop_counter #(.STOP(OUT_H)) u_orow (
        .clk(clk), .rst(rst), .clr(clr), .en(ocol_co), .cnt(orow), .co(orow_co)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!bus.abort && bus.start) state_d = ST_RUN;
            ST_RUN: begin
                if (bus.abort)
                    state_d = ST_IDLE;
                else if (orow_co)
                    state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    assign row_sum = IA_W'(orow) + IA_W'(krow);
    assign col_sum = IA_W'(ocol) + IA_W'(kcol);

    assign bus.img_addr  = row_sum * IA_W'(IMG_W) + col_sum;
    assign bus.w_addr    = WA_W'(krow) * WA_W'(K) + WA_W'(kcol);
    assign bus.win_first = run & (kcol == '0) & (krow == '0);
    assign bus.win_last  = run & (kcol == KC_W'(K - 1)) & (krow == KC_W'(K - 1));
    assign bus.out_valid = run;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);

endmodule
